// File: rtl/xt_bus_pkg.sv
// Shared state encoding, default widths and counter helpers for the XT bus requester.
package xt_bus_pkg;

  localparam int DEF_ADDR_WIDTH    = 32;
  localparam int DEF_DATA_WIDTH    = 32;
  localparam int DEF_GRANT_TIMEOUT = 16;
  localparam int CNT_WIDTH         = 8;

  localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_XFER = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  // Saturating increment: holds at all-ones instead of wrapping to zero.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    logic [CNT_WIDTH-1:0] r;
    if (v == CNT_MAX) begin
      r = v;
    end else begin
      r = v + CNT_ONE;
    end
    return r;
  endfunction

endpackage

// File: rtl/xt_bus_requester.sv
// Single-command bus requester: latches a command, arbitrates for the bus,
// performs one transfer and returns a one-cycle response (error on grant timeout).
module xt_bus_requester
  import xt_bus_pkg::*;
#(
  parameter int ADDR_WIDTH    = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int GRANT_TIMEOUT = DEF_GRANT_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_we,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_error,
  output logic                  read_req,
  output logic                  write_req,
  input  logic                  read_grant,
  input  logic                  write_grant,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [DATA_WIDTH-1:0] bus_wdata,
  output logic                  bus_we,
  input  logic [DATA_WIDTH-1:0] bus_rdata,
  input  logic                  bus_ack
);

  localparam logic [CNT_WIDTH-1:0]  TIMEOUT_LAST = CNT_WIDTH'(GRANT_TIMEOUT - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO    = {ADDR_WIDTH{1'b0}};
  localparam logic [DATA_WIDTH-1:0] DATA_ZERO    = {DATA_WIDTH{1'b0}};

  state_e                  state_r, state_s;
  logic [CNT_WIDTH-1:0]    cnt_r, cnt_s;
  logic                    we_r, we_s;
  logic [ADDR_WIDTH-1:0]   addr_r, addr_s;
  logic [DATA_WIDTH-1:0]   wdata_r, wdata_s;
  logic                    grant_s;
  logic                    cmd_ready_s, rsp_valid_s, rsp_error_s;
  logic                    read_req_s, write_req_s, bus_we_s;
  logic [DATA_WIDTH-1:0]   rsp_rdata_s, bus_wdata_s;
  logic [ADDR_WIDTH-1:0]   bus_addr_s;

  // Only the grant matching the latched direction counts.
  always_comb begin
    if (we_r) begin
      grant_s = write_grant;
    end else begin
      grant_s = read_grant;
    end
  end

  // Next state, command latch, timeout counter and response payload.
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    we_s        = we_r;
    addr_s      = addr_r;
    wdata_s     = wdata_r;
    rsp_rdata_s = DATA_ZERO;
    rsp_error_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (cmd_valid) begin
          state_s = ST_REQ;
          cnt_s   = CNT_ZERO;
          we_s    = cmd_we;
          addr_s  = cmd_addr;
          wdata_s = cmd_wdata;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (grant_s) begin
          state_s = ST_XFER;
        end else if (cnt_r >= TIMEOUT_LAST) begin
          state_s     = ST_RESP;
          rsp_error_s = 1'b1;
        end else begin
          cnt_s = sat_inc(cnt_r);
        end
      end
      ST_XFER: begin
        // An ack wins over a simultaneous grant drop.
        if (bus_ack) begin
          state_s = ST_RESP;
          if (!we_r) begin
            rsp_rdata_s = bus_rdata;
          end else begin
            rsp_rdata_s = DATA_ZERO;
          end
        end else if (!grant_s) begin
          state_s = ST_REQ;
          cnt_s   = CNT_ZERO;
        end else begin
          state_s = ST_XFER;
        end
      end
      ST_RESP: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // Output values for the upcoming state, so every port comes straight from a flop.
  always_comb begin
    cmd_ready_s = 1'b0;
    rsp_valid_s = 1'b0;
    read_req_s  = 1'b0;
    write_req_s = 1'b0;
    bus_we_s    = 1'b0;
    bus_addr_s  = ADDR_ZERO;
    bus_wdata_s = DATA_ZERO;
    case (state_s)
      ST_IDLE: cmd_ready_s = 1'b1;
      ST_REQ: begin
        read_req_s  = !we_s;
        write_req_s = we_s;
      end
      ST_XFER: begin
        read_req_s  = !we_s;
        write_req_s = we_s;
        bus_we_s    = we_s;
        bus_addr_s  = addr_s;
        bus_wdata_s = wdata_s;
      end
      ST_RESP: rsp_valid_s = 1'b1;
      default: cmd_ready_s = 1'b0;
    endcase
  end

  // State, latch and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      cnt_r     <= CNT_ZERO;
      we_r      <= 1'b0;
      addr_r    <= ADDR_ZERO;
      wdata_r   <= DATA_ZERO;
      cmd_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= DATA_ZERO;
      rsp_error <= 1'b0;
      read_req  <= 1'b0;
      write_req <= 1'b0;
      bus_addr  <= ADDR_ZERO;
      bus_wdata <= DATA_ZERO;
      bus_we    <= 1'b0;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      we_r      <= we_s;
      addr_r    <= addr_s;
      wdata_r   <= wdata_s;
      cmd_ready <= cmd_ready_s;
      rsp_valid <= rsp_valid_s;
      rsp_rdata <= rsp_rdata_s;
      rsp_error <= rsp_error_s;
      read_req  <= read_req_s;
      write_req <= write_req_s;
      bus_addr  <= bus_addr_s;
      bus_wdata <= bus_wdata_s;
      bus_we    <= bus_we_s;
    end
  end

endmodule

// File: tb/tb_xt_bus_requester.sv
// Self-checking bench: transaction-level reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_xt_bus_requester;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0, cmd_we = 1'b0;
  logic [31:0] cmd_addr = 32'd0, cmd_wdata = 32'd0;
  logic        cmd_ready, rsp_valid, rsp_error, read_req, write_req, bus_we;
  logic [31:0] rsp_rdata, bus_addr, bus_wdata;
  logic        read_grant = 1'b0, write_grant = 1'b0, bus_ack = 1'b0;
  logic [31:0] bus_rdata = 32'd0;

  int n_tests = 0;
  int n_fail  = 0;

  xt_bus_requester #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .GRANT_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
    .read_req(read_req), .write_req(write_req),
    .read_grant(read_grant), .write_grant(write_grant),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_we(bus_we),
    .bus_rdata(bus_rdata), .bus_ack(bus_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: one outstanding command, described by whether it is
  // waiting for a grant, on the bus, or being answered.
  bit          m_busy = 0, m_on_bus = 0, m_resp = 0, m_we = 0, m_err = 0;
  int          m_waited = 0;
  logic [31:0] m_addr = 32'd0, m_wdata = 32'd0, m_rdata = 32'd0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 0; m_on_bus = 0; m_resp = 0; m_waited = 0;
      m_we = 0; m_addr = 32'd0; m_wdata = 32'd0;
    end else if (m_resp) begin
      m_resp = 0;
      m_busy = 0;
    end else if (!m_busy) begin
      if (cmd_valid) begin
        m_busy = 1; m_on_bus = 0; m_waited = 0;
        m_we = cmd_we; m_addr = cmd_addr; m_wdata = cmd_wdata;
      end
    end else if (!m_on_bus) begin
      if (m_we ? write_grant : read_grant) begin
        m_on_bus = 1;
      end else begin
        m_waited++;
        if (m_waited >= TO) begin
          m_resp = 1; m_err = 1; m_rdata = 32'd0;
        end
      end
    end else begin
      if (bus_ack) begin
        m_resp = 1; m_err = 0; m_on_bus = 0;
        m_rdata = m_we ? 32'd0 : bus_rdata;
      end else if (!(m_we ? write_grant : read_grant)) begin
        m_on_bus = 0;
        m_waited = 0;
      end
    end
  end

  // Observation counters for the directed scenarios.
  int          cyc = 0, acc_cyc = 0, lat = 0;
  int          n_rreq, n_wreq, n_bwe, n_rsp, n_both, n_acc, n_addr;
  logic [31:0] last_rdata, last_bwdata, watch_addr;
  logic        last_err, rsp_prev, ready_after;

  task automatic clear_stats(input logic [31:0] wa);
    n_rreq = 0; n_wreq = 0; n_bwe = 0; n_rsp = 0; n_both = 0; n_acc = 0; n_addr = 0;
    last_rdata = 32'd0; last_bwdata = 32'd0; last_err = 1'b0;
    rsp_prev = 1'b0; ready_after = 1'b0; watch_addr = wa;
  endtask

  always @(posedge clk) cyc++;

  // Every-cycle comparison against the model, plus counter updates.
  always @(negedge clk) begin
    chk("cmd_ready", cmd_ready, !m_busy);
    chk("read_req",  read_req,  m_busy && !m_resp && !m_we);
    chk("write_req", write_req, m_busy && !m_resp && m_we);
    chk("bus_we",    bus_we,    m_on_bus && m_we);
    chk("bus_addr",  bus_addr,  m_on_bus ? m_addr : 32'd0);
    chk("bus_wdata", bus_wdata, m_on_bus ? m_wdata : 32'd0);
    chk("rsp_valid", rsp_valid, m_resp);
    chk("rsp_rdata", rsp_rdata, m_resp ? m_rdata : 32'd0);
    chk("rsp_error", rsp_error, m_resp && m_err);
    if (read_req) n_rreq++;
    if (write_req) n_wreq++;
    if (read_req && write_req) n_both++;
    if (bus_we) begin n_bwe++; last_bwdata = bus_wdata; end
    if (bus_addr == watch_addr) n_addr++;
    if (rsp_prev) ready_after = cmd_ready;
    rsp_prev = rsp_valid;
    if (rsp_valid) begin
      n_rsp++; last_rdata = rsp_rdata; last_err = rsp_error; lat = cyc - acc_cyc;
    end
    if (cmd_valid && cmd_ready) begin n_acc++; acc_cyc = cyc; end
  end

  initial begin
    clear_stats(32'hFFFF_FFFF);
    repeat (3) @(posedge clk);
    #1;
    chk("reset_cmd_ready", cmd_ready, 1'b1);
    chk("reset_rsp_valid", rsp_valid, 1'b0);
    chk("reset_read_req",  read_req,  1'b0);
    chk("reset_bus_addr",  bus_addr,  32'd0);
    rst = 1'b0;
    step();
    chk("post_reset_ready", cmd_ready, 1'b1);

    // Read, grant after two REQ cycles, ack one cycle later.
    clear_stats(32'h40);
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 32'h40; step();
    cmd_valid = 1'b0; step();
    read_grant = 1'b1; step();
    bus_ack = 1'b1; bus_rdata = 32'hDEAD_BEEF; step();
    read_grant = 1'b0; bus_ack = 1'b0; bus_rdata = 32'd0; step(); step();
    chk("rd_req_cycles", n_rreq, 3);
    chk("rd_wreq_cycles", n_wreq, 0);
    chk("rd_rsp_count", n_rsp, 1);
    chk("rd_rdata", last_rdata, 32'hDEAD_BEEF);
    chk("rd_error", last_err, 1'b0);
    chk("rd_addr_cycles", n_addr, 1);
    chk("rd_latency", lat, 4);

    // Write with immediate grant and ack: minimum latency.
    clear_stats(32'h10);
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 32'h10; cmd_wdata = 32'h1234_5678;
    write_grant = 1'b1; bus_ack = 1'b1; step();
    cmd_valid = 1'b0; step(); step();
    write_grant = 1'b0; bus_ack = 1'b0; step(); step();
    chk("wr_wreq_cycles", n_wreq, 2);
    chk("wr_rreq_cycles", n_rreq, 0);
    chk("wr_bus_we_cycles", n_bwe, 1);
    chk("wr_bus_wdata", last_bwdata, 32'h1234_5678);
    chk("wr_rsp_count", n_rsp, 1);
    chk("wr_latency", lat, 3);
    chk("wr_rdata_zero", last_rdata, 32'd0);

    // Read timeout; a wrong-direction grant is held high throughout.
    clear_stats(32'h80);
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 32'h80; write_grant = 1'b1; step();
    cmd_valid = 1'b0; repeat (4) step();
    step(); step();
    write_grant = 1'b0;
    chk("to_req_cycles", n_rreq, 4);
    chk("to_wreq_cycles", n_wreq, 0);
    chk("to_rsp_count", n_rsp, 1);
    chk("to_error", last_err, 1'b1);
    chk("to_rdata", last_rdata, 32'd0);
    chk("to_ready_after", ready_after, 1'b1);
    chk("to_latency", lat, 5);

    // Grant dropped in XFER, regranted later, then acked.
    clear_stats(32'h44);
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 32'h44; step();
    cmd_valid = 1'b0; read_grant = 1'b1; step();
    read_grant = 1'b0; step(); step();
    read_grant = 1'b1; step();
    bus_ack = 1'b1; bus_rdata = 32'hCAFE_F00D; step();
    read_grant = 1'b0; bus_ack = 1'b0; bus_rdata = 32'd0; step(); step();
    chk("drop_req_cycles", n_rreq, 5);
    chk("drop_rsp_count", n_rsp, 1);
    chk("drop_error", last_err, 1'b0);
    chk("drop_rdata", last_rdata, 32'hCAFE_F00D);
    chk("drop_addr_cycles", n_addr, 2);

    // Reset during XFER, then a normal command.
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 32'h20; cmd_wdata = 32'h55AA;
    write_grant = 1'b1; step();
    cmd_valid = 1'b0; step();
    chk("rst_pre_bus_we", bus_we, 1'b1);
    rst = 1'b1; #1;
    chk("rst_write_req", write_req, 1'b0);
    chk("rst_bus_we", bus_we, 1'b0);
    chk("rst_bus_addr", bus_addr, 32'd0);
    chk("rst_cmd_ready", cmd_ready, 1'b1);
    step();
    rst = 1'b0; write_grant = 1'b0; step();
    clear_stats(32'hFFFF_FFFF);
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 32'h40;
    read_grant = 1'b1; bus_ack = 1'b1; bus_rdata = 32'h0BAD_F00D; step();
    cmd_valid = 1'b0; step(); step();
    read_grant = 1'b0; bus_ack = 1'b0; step(); step();
    chk("after_rst_rsp_count", n_rsp, 1);
    chk("after_rst_rdata", last_rdata, 32'h0BAD_F00D);
    chk("after_rst_latency", lat, 3);

    // Back-to-back commands with cmd_valid held high.
    clear_stats(32'hFFFF_FFFF);
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 32'h100;
    read_grant = 1'b1; write_grant = 1'b1; bus_ack = 1'b1;
    repeat (12) step();
    cmd_valid = 1'b0; read_grant = 1'b0; write_grant = 1'b0; bus_ack = 1'b0;
    step(); step(); step(); step();
    chk("b2b_rsp_count", n_rsp, 3);
    chk("b2b_accepts", n_acc, 3);
    chk("b2b_both_req", n_both, 0);

    // Randomized traffic: frequent grants first, then sparse ones to hit timeouts.
    for (int i = 0; i < 1600; i++) begin
      cmd_valid   = ($urandom_range(0, 1) == 0);
      cmd_we      = $urandom_range(0, 1);
      cmd_addr    = $urandom;
      cmd_wdata   = $urandom;
      if (i < 800) begin
        read_grant  = ($urandom_range(0, 2) != 0);
        write_grant = ($urandom_range(0, 2) != 0);
      end else begin
        read_grant  = ($urandom_range(0, 6) == 0);
        write_grant = ($urandom_range(0, 6) == 0);
      end
      bus_ack     = $urandom_range(0, 1);
      bus_rdata   = $urandom;
      rst         = ($urandom_range(0, 149) == 0);
      step();
    end
    rst = 1'b0; cmd_valid = 1'b0; read_grant = 1'b0; write_grant = 1'b0; bus_ack = 1'b0;
    repeat (10) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/xt_bus_requester.md
XT_BUS_REQUESTER -- requirements
Module: xt_bus_requester

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, bus address width.
REQ-002 Parameter DATA_WIDTH, default 32, bus data width.
REQ-003 Parameter GRANT_TIMEOUT, default 16, maximum REQ-state cycles before an error response; legal range 1..255.
REQ-004 clk  input  1  single clock; all state changes on the rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 cmd_valid  input  1, cmd_ready  output  1: command handshake; transfer on cycles where both are high.
REQ-007 cmd_we  input  1 (1 = write); cmd_addr  input  ADDR_WIDTH; cmd_wdata  input  DATA_WIDTH.
REQ-008 rsp_valid  output  1; rsp_rdata  output  DATA_WIDTH; rsp_error  output  1 (grant timeout).
REQ-009 read_req, write_req  output  1 each: this port's request bits toward the arbiter.
REQ-010 read_grant, write_grant  input  1 each: this port's grant bits from the arbiter.
REQ-011 bus_addr  output  ADDR_WIDTH; bus_wdata  output  DATA_WIDTH; bus_we  output  1; bus_rdata  input  DATA_WIDTH; bus_ack  input  1.

Function
REQ-012 The FSM SHALL have states IDLE, REQ, XFER and RESP.
REQ-013 IDLE: cmd_ready = 1; on cmd_valid, latch we/addr/wdata and go to REQ.
REQ-014 REQ: assert read_req if latched we = 0, otherwise write_req; never assert both; count cycles.
REQ-015 REQ: a matching grant (read_grant for reads, write_grant for writes) sampled high moves the FSM to XFER.
REQ-016 REQ: if the count reaches GRANT_TIMEOUT without a grant, go to RESP with rsp_error = 1 and rsp_rdata = 0.
REQ-017 XFER: keep the request high; drive bus_addr and bus_wdata from latched values; bus_we = latched we.
REQ-018 XFER: bus_ack sampled high moves the FSM to RESP; a read captures bus_rdata into rsp_rdata; rsp_error = 0.
REQ-019 XFER: if the grant drops without bus_ack (arbiter deadlock reset), return to REQ, reset the timeout count and keep the latched command.
REQ-020 RESP: rsp_valid = 1 for exactly one cycle with no back-pressure; read_req and write_req = 0; next state IDLE.
REQ-021 Outside XFER, bus_addr, bus_wdata and bus_we SHALL be 0; cmd_ready SHALL be 0 outside IDLE.
REQ-022 All outputs SHALL be registered; minimum latency from command acceptance to rsp_valid is 3 cycles (REQ 1, XFER 1, RESP).
REQ-023 Grant held high in IDLE or RESP, or a grant of the wrong direction, SHALL be ignored.
REQ-024 bus_ack and a grant drop in the same XFER cycle SHALL be treated as a completed transfer.
REQ-025 The timeout counter SHALL saturate and never wrap.

Reset
REQ-026 rst high SHALL force state IDLE, discard any latched command and zero the timeout counter, with immediate effect, including mid-transfer.
REQ-027 Outputs during and after reset: cmd_ready 1, all other outputs 0.

Structure
REQ-028 Package xt_bus_pkg SHALL hold the state enum and the default width/timeout constants.
REQ-029 The block SHALL be a single module; no sub-module is required.

Verification
REQ-030 Read of addr 0x0000_0040; grant 2 cycles after req; ack 1 cycle later with rdata 0xDEAD_BEEF -> read_req high 3 cycles, rsp_valid once, rsp_rdata 0xDEAD_BEEF, rsp_error 0.
REQ-031 Write of 0x1234_5678 to 0x10; grant and ack immediate -> write_req only, bus_we 1 for 1 cycle, rsp_valid 3 cycles after acceptance.
REQ-032 Read, grant never given, GRANT_TIMEOUT=4 -> req high 4 cycles, rsp_valid with rsp_error 1, req drops, cmd_ready 1 the following cycle.
REQ-033 Grant in XFER, grant dropped without ack, regranted 2 cycles later, then ack -> single rsp_valid, no error, latched addr unchanged throughout.
REQ-034 rst asserted in XFER -> all outputs except cmd_ready 0 immediately; next command handled normally.
REQ-035 Back-to-back commands with cmd_valid held high -> second command accepted the cycle after RESP; requests never overlap.
